// File: rtl/lsu_load.sv
// Load unit: issues word-aligned data-memory reads, extracts and extends the addressed lane.
// Optional response timeout is enabled by defining LSU_LOAD_TIMEOUT_EN.
module lsu_load #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mem_read_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  output logic        d_req_o,
  output logic [31:0] d_addr_o,
  input  logic        d_gnt_i,
  input  logic [31:0] d_rdata_i,
  input  logic        d_rvalid_i,
  output logic [31:0] rdata_o,
  output logic        valid_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  logic [2:0]          funct3_q;
  logic [1:0]          off_q;
  logic                fault_c;
  logic                accept_c;
  logic                capture_c;
  logic                abort_c;
  logic                timeout_c;
  logic [BYTE_W-1:0]   byte_c;
  logic [HALF_W-1:0]   half_c;
  logic [WORD_W-1:0]   ext_c;

  if (TIMEOUT_CYCLES == 0) begin : g_timeout_check
    $error("lsu_load: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef LSU_LOAD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // Counts WAIT cycles without a response; held at zero outside WAIT so it clears on entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state != S_WAIT)) begin
      wait_cnt <= '0;
    end else if (!d_rvalid_i) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_c = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Misaligned or reserved load types fault without touching memory.
  always_comb begin
    fault_c = 1'b1;
    case (funct3_i)
      F3_LB, F3_LBU: fault_c = 1'b0;
      F3_LH, F3_LHU: fault_c = addr_i[0];
      F3_LW:         fault_c = |addr_i[1:0];
      default:       fault_c = 1'b1;
    endcase
  end

  // Lane select and sign/zero extension of the returned word.
  always_comb begin
    byte_c = d_rdata_i[7:0];
    case (off_q)
      2'd1:    byte_c = d_rdata_i[15:8];
      2'd2:    byte_c = d_rdata_i[23:16];
      2'd3:    byte_c = d_rdata_i[31:24];
      default: byte_c = d_rdata_i[7:0];
    endcase
    half_c = off_q[1] ? d_rdata_i[31:16] : d_rdata_i[15:0];
    ext_c  = d_rdata_i;
    case (funct3_q)
      F3_LB:   ext_c = {{(WORD_W - BYTE_W){byte_c[BYTE_W-1]}}, byte_c};
      F3_LBU:  ext_c = {{(WORD_W - BYTE_W){1'b0}}, byte_c};
      F3_LH:   ext_c = {{(WORD_W - HALF_W){half_c[HALF_W-1]}}, half_c};
      F3_LHU:  ext_c = {{(WORD_W - HALF_W){1'b0}}, half_c};
      default: ext_c = d_rdata_i;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx  = state;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    abort_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_read_i) begin
          accept_c = 1'b1;
          state_nx = fault_c ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (d_gnt_i) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (d_rvalid_i) begin
          capture_c = 1'b1;
          state_nx  = S_DONE;
        end else if (timeout_c) begin
          abort_c  = 1'b1;
          state_nx = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      d_req_o  <= 1'b0;
      d_addr_o <= '0;
      rdata_o  <= '0;
      valid_o  <= 1'b0;
      err_o    <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      state   <= state_nx;
      busy_o  <= (state_nx != S_IDLE);
      d_req_o <= (state_nx == S_REQ);
      valid_o <= (state_nx == S_DONE);
      if (accept_c) begin
        funct3_q <= funct3_i;
        off_q    <= addr_i[1:0];
        d_addr_o <= {addr_i[31:2], 2'b00};
        err_o    <= fault_c;
        if (fault_c) begin
          rdata_o <= '0;
        end
      end
      if (capture_c) begin
        rdata_o <= ext_c;
        err_o   <= 1'b0;
      end
      if (abort_c) begin
        rdata_o <= '0;
        err_o   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_load.sv
// Randomized bench for lsu_load: a transaction-level model fills per-cycle expectations
// that a negedge monitor compares against the DUT outputs.
module tb_lsu_load;

  localparam int unsigned MAXC = 8192;
  localparam int unsigned TO   = 4;
`ifdef LSU_LOAD_TIMEOUT_EN
  localparam int unsigned MAXR = 2;
`else
  localparam int unsigned MAXR = 9;
`endif

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic        err;
  logic        busy;

  lsu_load #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .mem_read_i (mem_read),
    .funct3_i   (funct3),
    .addr_i     (addr),
    .d_req_o    (d_req),
    .d_addr_o   (d_addr),
    .d_gnt_i    (d_gnt),
    .d_rdata_i  (d_rdata),
    .d_rvalid_i (d_rvalid),
    .rdata_o    (rdata),
    .valid_o    (valid),
    .err_o      (err),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  tests = 0;
  int  fails = 0;
  bit  chk_en = 1'b0;

  bit          exp_valid [MAXC];
  bit          exp_busy  [MAXC];
  bit          exp_req   [MAXC];
  bit          exp_err   [MAXC];
  bit          exp_clr   [MAXC];
  logic [31:0] exp_rd    [MAXC];
  logic [31:0] exp_addr  [MAXC];
  logic [31:0] hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference: size-based alignment rule and shift-then-extend lane extraction.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] res, output logic fault);
    int unsigned size = 1 << f3[1:0];
    logic [31:0] lane;
    fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || ((a % size) != 0);
    res   = '0;
    lane  = d >> (8 * a[1:0]);
    if (!fault) begin
      case (f3[1:0])
        2'd0:    res = f3[2] ? {24'h0, lane[7:0]}  : 32'($signed(lane[7:0]));
        2'd1:    res = f3[2] ? {16'h0, lane[15:0]} : 32'($signed(lane[15:0]));
        default: res = lane;
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic noise_busy();
    mem_read = 1'($urandom);
    funct3   = 3'($urandom);
    addr     = $urandom;
  endtask

  // Drives one load; g = REQ cycles before grant, r = WAIT cycles before response.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] data,
                          input int g, input int r);
    int a = cyc;
    int d;
    logic [31:0] res;
    logic fault;
    model(f3, ad, data, res, fault);
    mem_read = 1'b1;
    funct3   = f3;
    addr     = ad;
    d_gnt    = 1'b0;
    d_rvalid = 1'($urandom);
    d_rdata  = $urandom;
    if (fault) begin
      exp_busy[a+1]  = 1'b1;
      exp_valid[a+1] = 1'b1;
      exp_err[a+1]   = 1'b1;
      exp_rd[a+1]    = '0;
      tick();
      noise_busy();
      tick();
    end else begin
      for (int i = a + 1; i <= a + 1 + g; i++) begin
        exp_req[i]  = 1'b1;
        exp_busy[i] = 1'b1;
        exp_addr[i] = ad & ~32'h3;
      end
      for (int i = a + 2 + g; i <= a + 2 + g + r; i++) exp_busy[i] = 1'b1;
      d = a + 3 + g + r;
      exp_busy[d]  = 1'b1;
      exp_valid[d] = 1'b1;
      exp_err[d]   = 1'b0;
      exp_rd[d]    = res;
      tick();
      for (int k = 0; k <= g; k++) begin
        d_gnt    = (k == g);
        d_rvalid = 1'($urandom);
        d_rdata  = $urandom;
        noise_busy();
        tick();
      end
      d_gnt = 1'b0;
      for (int k = 0; k <= r; k++) begin
        d_rvalid = (k == r);
        d_rdata  = (k == r) ? data : $urandom;
        noise_busy();
        tick();
      end
      d_rvalid = 1'b0;
      noise_busy();
      tick();
    end
    mem_read = 1'b0;
    d_rvalid = 1'($urandom);
    d_rdata  = $urandom;
  endtask

  // Per-cycle comparison against the expectations laid down by the driver.
  always @(negedge clk) begin
    if (chk_en && (cyc < MAXC)) begin
      if (exp_clr[cyc]) hold = '0;
      if (exp_valid[cyc]) hold = exp_rd[cyc];
      check("valid", 32'(valid), 32'(exp_valid[cyc]));
      check("busy", 32'(busy), 32'(exp_busy[cyc]));
      check("req", 32'(d_req), 32'(exp_req[cyc]));
      check("rdata", rdata, hold);
      if (exp_valid[cyc]) check("err", 32'(err), 32'(exp_err[cyc]));
      if (exp_req[cyc]) check("d_addr", d_addr, exp_addr[cyc]);
    end
  end

  initial begin
    logic [31:0] pr;
    logic        pe;
    int          a;
    rst = 1'b1; mem_read = 1'b0; funct3 = '0; addr = '0;
    d_gnt = 1'b0; d_rdata = '0; d_rvalid = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Hand-computed values pinning the reference model.
    model(3'b000, 32'h1003, 32'h80FF_1234, pr, pe);
    check("pin_lb", pr, 32'hFFFF_FF80);
    model(3'b101, 32'h2002, 32'hBEEF_0001, pr, pe);
    check("pin_lhu", pr, 32'h0000_BEEF);
    model(3'b001, 32'h2002, 32'hBEEF_0001, pr, pe);
    check("pin_lh", pr, 32'hFFFF_BEEF);
    model(3'b010, 32'h3001, 32'h0, pr, pe);
    check("pin_lw_mis", 32'(pe), 32'd1);
    model(3'b011, 32'h3000, 32'h0, pr, pe);
    check("pin_f3_011", 32'(pe), 32'd1);
    model(3'b100, 32'h5001, 32'h0000_AB00, pr, pe);
    check("pin_lbu", pr, 32'h0000_00AB);

    run_load(3'b000, 32'h1003, 32'h80FF_1234, 0, 0);
    check("lb_rdata", rdata, 32'hFFFF_FF80);
    run_load(3'b101, 32'h2002, 32'hBEEF_0001, 0, 0);
    check("lhu_rdata", rdata, 32'h0000_BEEF);
    run_load(3'b001, 32'h2002, 32'hBEEF_0001, 1, 2);
    check("lh_rdata", rdata, 32'hFFFF_BEEF);
    run_load(3'b010, 32'h3001, 32'hDEAD_BEEF, 0, 0);
    check("lw_mis_rdata", rdata, 32'h0);
    run_load(3'b011, 32'h3000, 32'hDEAD_BEEF, 0, 0);
    check("f3_011_rdata", rdata, 32'h0);
    run_load(3'b010, 32'h4000, 32'h1234_5678, 3, 1);
    check("lw_slow_rdata", rdata, 32'h1234_5678);

    // Reset while waiting for a response; the response then lands in IDLE.
    a = cyc;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h6000;
    exp_req[a+1] = 1'b1; exp_addr[a+1] = 32'h6000;
    exp_busy[a+1] = 1'b1; exp_busy[a+2] = 1'b1; exp_busy[a+3] = 1'b1;
    exp_clr[a+4] = 1'b1;
    tick(); noise_busy(); d_gnt = 1'b1; d_rvalid = 1'b0;
    tick(); noise_busy(); d_gnt = 1'b0;
    tick(); rst = 1'b1; mem_read = 1'b0;
    tick(); rst = 1'b0; d_rvalid = 1'b1; d_rdata = $urandom;
    check("rst_rdata", rdata, 32'h0);
    tick(); d_rvalid = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    run_load(3'b100, 32'h5001, 32'h0000_AB00, 0, 0);
    check("lbu_after_rst", rdata, 32'h0000_00AB);

`ifdef LSU_LOAD_TIMEOUT_EN
    // Grant without response: abort after TO WAIT cycles, late response dropped.
    a = cyc;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h7000;
    exp_req[a+1] = 1'b1; exp_addr[a+1] = 32'h7000;
    for (int i = a + 1; i <= a + 2 + int'(TO); i++) exp_busy[i] = 1'b1;
    exp_valid[a+2+TO] = 1'b1; exp_err[a+2+TO] = 1'b1; exp_rd[a+2+TO] = '0;
    tick(); noise_busy(); d_gnt = 1'b1; d_rvalid = 1'b0;
    tick(); d_gnt = 1'b0;
    for (int k = 0; k < int'(TO); k++) begin
      noise_busy(); d_rvalid = 1'b0;
      tick();
    end
    noise_busy();
    tick(); mem_read = 1'b0; d_rvalid = 1'b1; d_rdata = $urandom;
    tick(); d_rvalid = 1'b0;
    check("timeout_rdata", rdata, 32'h0);
`endif

    for (int n = 0; n < 200; n++) begin
      int gap = $urandom_range(0, 2);
      for (int k = 0; k < gap; k++) begin
        mem_read = 1'b0; d_rvalid = 1'($urandom); d_rdata = $urandom;
        tick();
      end
      run_load(3'($urandom), $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, MAXR));
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_load.md
Name: lsu_load

Overview:
- Load-side counterpart of the store byte-enable path in the LSU.
- Accepts a load command from the execute stage and issues a word-aligned read request to data memory over a request/grant/response-valid handshake.
- Extracts the addressed byte, halfword or word from the returned word, sign- or zero-extends it, and presents a registered 32-bit result with a one-cycle valid pulse.
- Detects misaligned and illegal loads locally and never issues a memory request for them.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT-state cycles before abort. Used only with the optional feature.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- mem_read_i  input  1  load command; sampled only in IDLE.
- funct3_i  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr_i  input  32  byte address of the load.
- d_req_o  output  1  memory read request.
- d_addr_o  output  32  word-aligned memory address, {addr[31:2],2'b00}.
- d_gnt_i  input  1  memory accepted the request.
- d_rdata_i  input  32  memory read data; valid only when d_rvalid_i=1.
- d_rvalid_i  input  1  read response valid.
- rdata_o  output  32  extended load result.
- valid_o  output  1  one-cycle pulse: rdata_o/err_o valid.
- err_o  output  1  load faulted; qualified by valid_o.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; all outputs 0 (d_req_o, d_addr_o, rdata_o, valid_o, err_o, busy_o).
- Reset mid-operation: return to IDLE; the captured command is discarded; no valid_o pulse is produced.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On mem_read_i=1, register funct3_i and addr_i.
  - Legal, aligned load -> REQ.
  - Misaligned or illegal load -> DONE with err=1.
  - d_rvalid_i is ignored in IDLE; late responses are dropped.
- Misaligned or illegal load means any of:
  - LH/LHU with addr[0]=1.
  - LW with addr[1:0]!=00.
  - funct3 of 011, 110 or 111.
- REQ:
  - d_req_o=1; d_addr_o holds stable until grant.
  - On d_gnt_i=1 -> WAIT; d_req_o drops the next cycle.
  - d_rvalid_i is ignored in REQ.
- WAIT:
  - On d_rvalid_i=1, capture and extract d_rdata_i into rdata_o, set err=0, -> DONE.
  - Unlimited wait unless the optional feature is enabled.
- DONE:
  - valid_o=1 for exactly one cycle, then -> IDLE.
  - rdata_o holds its value until the next DONE or reset.
  - On an error, rdata_o=0.
- Extraction (lane selected by registered addr[1:0]):
  - Byte lane k = d_rdata_i[8k+7:8k]; halfword lane: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Latency: command accepted at edge N.
  - With d_gnt_i in REQ and d_rvalid_i on the first WAIT cycle, valid_o is high in cycle N+3.
  - Fault path: valid_o is high in cycle N+1.
- Throughput:
  - mem_read_i is ignored while busy_o=1.
  - A new command can be accepted in the cycle after DONE.
- Handshake with the caller: the caller holds funct3_i/addr_i only for the acceptance cycle; the block registers them.

Optional Feature:
- Macro: LSU_LOAD_TIMEOUT_EN.
- Enabled:
  - A counter clears on entry to WAIT and increments each WAIT cycle without d_rvalid_i.
  - On reaching TIMEOUT_CYCLES: -> DONE with err=1 and rdata_o=0.
  - A d_rvalid_i arriving after the abort falls in IDLE and is ignored.
- Disabled: no counter; WAIT holds indefinitely; err_o reports only misaligned or illegal loads.

Test Plan:
- LB, addr 0x1003, memory returns 0x80FF_1234, zero-wait:
  - d_addr_o=0x1000.
  - valid_o at N+3 with rdata_o=0xFFFF_FF80, err_o=0.
- LHU, addr 0x2002, data 0xBEEF_0001:
  - rdata_o=0x0000_BEEF.
  - LH to the same address: rdata_o=0xFFFF_BEEF.
- LW, addr 0x3001:
  - d_req_o never asserts.
  - valid_o at N+1 with err_o=1, rdata_o=0.
  - funct3=011 at an aligned address gives the same response.
- LW, addr 0x4000, d_gnt_i withheld 3 cycles, d_rvalid_i 2 cycles after grant, data 0x1234_5678:
  - d_req_o high 4 cycles; d_addr_o stable throughout.
  - rdata_o=0x1234_5678.
  - A second mem_read_i pulse while busy_o=1 is ignored.
- rst_i asserted in WAIT, then d_rvalid_i arrives:
  - Next cycle all outputs are 0, state is IDLE.
  - No valid_o pulse.
  - A subsequent LBU at 0x5001 with data 0x0000_AB00 returns 0x0000_00AB.
- LSU_LOAD_TIMEOUT_EN, TIMEOUT_CYCLES=4, grant with no response:
  - valid_o with err_o=1 after 4 WAIT cycles.
  - A late d_rvalid_i is ignored.
